// File: rtl/i2s_lj_transmitter.sv
// ----------------------------------------------------------------------------
// i2s_lj_transmitter
//
// Serialises one stereo PCM pair per sample tick into a left-justified
// BCLK/LRCK/SDATA stream for an external DAC. Samples arrive through a
// one-entry valid/ready holding register; each rising edge of sample_clk
// (same clock domain as clk_in) starts one frame of 2*SLOT_BITS bit clocks.
//
// Optional feature macro: I2S_UNDERRUN_REPEAT_EN
//   defined   : an underrun frame repeats the last transmitted pair
//   undefined : an underrun frame sends all-zero slots
//
// Ports
//   clk_in      in   system clock, all logic on its rising edge
//   reset       in   synchronous, active-high
//   sample_clk  in   divided sample-rate clock; rising edge = frame start
//   s_left      in   left sample, two's complement
//   s_right     in   right sample, two's complement
//   s_valid     in   sample pair valid
//   s_ready     out  holding register empty
//   bclk        out  bit clock
//   lrck        out  1 = left slot, 0 = right slot
//   sdata       out  serial data, MSB first
//   underrun    out  one-cycle pulse: frame started with nothing held
//   frame_err   out  one-cycle pulse: sample tick during an active frame
// ----------------------------------------------------------------------------
module i2s_lj_transmitter #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SLOT_BITS    = 32,
  parameter int BCLK_HALF    = 8
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    sample_clk,
  input  logic [SAMPLE_WIDTH-1:0] s_left,
  input  logic [SAMPLE_WIDTH-1:0] s_right,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic                    bclk,
  output logic                    lrck,
  output logic                    sdata,
  output logic                    underrun,
  output logic                    frame_err
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int BIT_W      = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int PH_W       = $clog2(2 * BCLK_HALF);

  // Phase counter value at which bclk goes high, and the last phase of a bit.
  localparam logic [PH_W-1:0]  PH_HIGH   = PH_W'(BCLK_HALF);
  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(2 * BCLK_HALF - 1);
  localparam logic [BIT_W-1:0] BIT_RIGHT = BIT_W'(SLOT_BITS);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_BITS - 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [0:0]              state_q, state_d;
  logic                    sc_q, sc_d;
  logic                    hold_full_q, hold_full_d;
  logic [SAMPLE_WIDTH-1:0] hold_l_q, hold_l_d;
  logic [SAMPLE_WIDTH-1:0] hold_r_q, hold_r_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [PH_W-1:0]         phase_q, phase_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic                    bclk_q, bclk_d;
  logic                    lrck_q, lrck_d;
  logic                    sdata_q, sdata_d;
  logic                    underrun_q, underrun_d;
  logic                    frame_err_q, frame_err_d;

`ifdef I2S_UNDERRUN_REPEAT_EN
  logic [SAMPLE_WIDTH-1:0] last_l_q, last_l_d;
  logic [SAMPLE_WIDTH-1:0] last_r_q, last_r_d;
`endif

  logic                    tick;
  logic                    ready_int;
  logic                    accept;
  logic [SAMPLE_WIDTH-1:0] load_l;
  logic [SAMPLE_WIDTH-1:0] load_r;
  logic [PH_W-1:0]         phase_next;
  logic [BIT_W-1:0]        bit_next;

  // Lay out one whole frame: each sample sits at the top of its slot, the
  // unused slot bits below it stay zero. Shifting left one bit per BCLK
  // then presents the stream MSB first.
  function automatic logic [FRAME_BITS-1:0] pack_frame(
    input logic [SAMPLE_WIDTH-1:0] l,
    input logic [SAMPLE_WIDTH-1:0] r
  );
    logic [FRAME_BITS-1:0] f;
    f = '0;
    f[FRAME_BITS-1 -: SAMPLE_WIDTH] = l;
    f[SLOT_BITS-1  -: SAMPLE_WIDTH] = r;
    return f;
  endfunction

  assign ready_int  = ~hold_full_q;
  assign s_ready    = ready_int & ~reset;
  assign accept     = s_valid & ready_int;
  assign tick       = sample_clk & ~sc_q;
  assign phase_next = phase_q + 1'b1;
  assign bit_next   = bit_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    sc_d        = sample_clk;
    hold_full_d = hold_full_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    shift_d     = shift_q;
    phase_d     = phase_q;
    bit_d       = bit_q;
    bclk_d      = bclk_q;
    lrck_d      = lrck_q;
    sdata_d     = sdata_q;
    underrun_d  = 1'b0;
    frame_err_d = 1'b0;
`ifdef I2S_UNDERRUN_REPEAT_EN
    last_l_d    = last_l_q;
    last_r_d    = last_r_q;
`endif

    // Fallback pair used when a frame starts with nothing held.
`ifdef I2S_UNDERRUN_REPEAT_EN
    load_l = last_l_q;
    load_r = last_r_q;
`else
    load_l = '0;
    load_r = '0;
`endif

    // A full register never accepts, so the capture below cannot collide
    // with the frame load clearing hold_full.
    if (accept) begin
      hold_l_d    = s_left;
      hold_r_d    = s_right;
      hold_full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          if (hold_full_q) begin
            load_l      = hold_l_q;
            load_r      = hold_r_q;
            hold_full_d = 1'b0;
          end else begin
            underrun_d = 1'b1;
          end
          shift_d = pack_frame(load_l, load_r);
          state_d = ST_ACTIVE;
          phase_d = '0;
          bit_d   = '0;
          bclk_d  = 1'b0;
          lrck_d  = 1'b1;
          sdata_d = load_l[SAMPLE_WIDTH-1];
`ifdef I2S_UNDERRUN_REPEAT_EN
          last_l_d = load_l;
          last_r_d = load_r;
`endif
        end
      end

      ST_ACTIVE: begin
        if (tick) begin
          frame_err_d = 1'b1;
        end
        if (phase_q == PH_LAST) begin
          // Falling BCLK edge: the only place lrck/sdata may change.
          phase_d = '0;
          bclk_d  = 1'b0;
          if (bit_q == BIT_LAST) begin
            state_d = ST_IDLE;
            bit_d   = '0;
            shift_d = '0;
            lrck_d  = 1'b0;
            sdata_d = 1'b0;
          end else begin
            bit_d   = bit_next;
            shift_d = shift_q << 1;
            lrck_d  = (bit_next < BIT_RIGHT);
            sdata_d = shift_q[FRAME_BITS-2];
          end
        end else begin
          phase_d = phase_next;
          bclk_d  = (phase_next >= PH_HIGH);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sc_q        <= 1'b0;
      hold_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      shift_q     <= '0;
      phase_q     <= '0;
      bit_q       <= '0;
      bclk_q      <= 1'b0;
      lrck_q      <= 1'b0;
      sdata_q     <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef I2S_UNDERRUN_REPEAT_EN
      last_l_q    <= '0;
      last_r_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sc_q        <= sc_d;
      hold_full_q <= hold_full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      shift_q     <= shift_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      bclk_q      <= bclk_d;
      lrck_q      <= lrck_d;
      sdata_q     <= sdata_d;
      underrun_q  <= underrun_d;
      frame_err_q <= frame_err_d;
`ifdef I2S_UNDERRUN_REPEAT_EN
      last_l_q    <= last_l_d;
      last_r_q    <= last_r_d;
`endif
    end
  end

  assign bclk      = bclk_q;
  assign lrck      = lrck_q;
  assign sdata     = sdata_q;
  assign underrun  = underrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_i2s_lj_transmitter.sv
// ----------------------------------------------------------------------------
// tb_i2s_lj_transmitter
//
// Drives stereo pairs and sample ticks into i2s_lj_transmitter with
// SAMPLE_WIDTH=8, SLOT_BITS=8, BCLK_HALF=2 (64-cycle frames). Accepted
// pairs go into a scoreboard queue; each frame pops the pair it should
// carry and the serial waveform is rebuilt cycle by cycle and compared.
// ----------------------------------------------------------------------------
module tb_i2s_lj_transmitter;

  localparam int SW      = 8;
  localparam int SB      = 8;
  localparam int BH      = 2;
  localparam int BIT_CYC = 2 * BH;
  localparam int FRAME_C = 2 * SB * BIT_CYC;

  logic          clk_in = 1'b0;
  logic          reset = 1'b1;
  logic          sample_clk = 1'b0;
  logic [SW-1:0] s_left = '0;
  logic [SW-1:0] s_right = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          bclk;
  logic          lrck;
  logic          sdata;
  logic          underrun;
  logic          frame_err;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [SW-1:0] l;
    logic [SW-1:0] r;
  } pair_t;

  typedef struct {
    logic          give;
    logic [SW-1:0] l;
    logic [SW-1:0] r;
    logic          bpHold;
    logic          sameAcc;
    logic [SW-1:0] sl;
    logic [SW-1:0] sr;
    logic          midAcc;
    logic [SW-1:0] ml;
    logic [SW-1:0] mr;
    logic          injectErr;
    int            abortAt;
    logic          expUnderrun;
  } vec_t;

  pair_t         sbq[$];
  vec_t          vecs[11];
  logic [SW-1:0] lastL = '0;
  logic [SW-1:0] lastR = '0;

  i2s_lj_transmitter #(
    .SAMPLE_WIDTH(SW),
    .SLOT_BITS   (SB),
    .BCLK_HALF   (BH)
  ) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .sample_clk(sample_clk),
    .s_left    (s_left),
    .s_right   (s_right),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .bclk      (bclk),
    .lrck      (lrck),
    .sdata     (sdata),
    .underrun  (underrun),
    .frame_err (frame_err)
  );

  // 100 MHz system clock.
  always #5 clk_in = ~clk_in;

  // Safety net so the run always terminates.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(
    input logic give, input logic [SW-1:0] l, input logic [SW-1:0] r,
    input logic bpHold,
    input logic sameAcc, input logic [SW-1:0] sl, input logic [SW-1:0] sr,
    input logic midAcc, input logic [SW-1:0] ml, input logic [SW-1:0] mr,
    input logic injectErr, input int abortAt, input logic expUnderrun
  );
    vec_t v;
    v.give = give; v.l = l; v.r = r; v.bpHold = bpHold;
    v.sameAcc = sameAcc; v.sl = sl; v.sr = sr;
    v.midAcc = midAcc; v.ml = ml; v.mr = mr;
    v.injectErr = injectErr; v.abortAt = abortAt; v.expUnderrun = expUnderrun;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s (vector %0d): got 0x%0h, want 0x%0h", name, idx, actual, expected);
    end
  endtask

  // Runs one vector: optional accept (with optional back-pressure), a tick,
  // then the whole frame is checked cycle by cycle against the model.
  task automatic applyStimulus(input int idx, input vec_t v);
    pair_t         expP;
    int            waveErr;
    int            errPulses;
    int            ph;
    int            k;
    int            j;
    logic          eb;
    logic          el;
    logic          ed;
    logic [SW-1:0] rxL;
    logic [SW-1:0] rxR;

    if (v.give) begin
      s_left  = v.l;
      s_right = v.r;
      s_valid = 1'b1;
      checkOutput("accept ready", idx, 32'(s_ready), 32'd1);
      expP.l = v.l;
      expP.r = v.r;
      sbq.push_back(expP);
      @(negedge clk_in);
      if (v.bpHold) begin
        s_left  = 8'h99;
        s_right = 8'h66;
        for (int i = 0; i < 3; i++) begin
          checkOutput("backpressure ready", idx, 32'(s_ready), 32'd0);
          @(negedge clk_in);
        end
      end else begin
        s_valid = 1'b0;
      end
    end

    if (sbq.size() > 0) begin
      expP = sbq.pop_front();
    end else begin
`ifdef I2S_UNDERRUN_REPEAT_EN
      expP.l = lastL;
      expP.r = lastR;
`else
      expP.l = '0;
      expP.r = '0;
`endif
    end
    lastL = expP.l;
    lastR = expP.r;

    sample_clk = 1'b1;
    if (v.sameAcc) begin
      s_left  = v.sl;
      s_right = v.sr;
      s_valid = 1'b1;
      checkOutput("same-cycle ready", idx, 32'(s_ready), 32'd1);
      sbq.push_back('{l: v.sl, r: v.sr});
    end

    waveErr   = 0;
    errPulses = 0;
    rxL       = '0;
    rxR       = '0;
    for (int c = 1; c <= FRAME_C; c++) begin
      @(negedge clk_in);
      if (c == 1) begin
        checkOutput("underrun pulse", idx, 32'(underrun), 32'(v.expUnderrun));
        if (v.bpHold) checkOutput("ready after consume", idx, 32'(s_ready), 32'd1);
        s_valid = 1'b0;
      end else if (underrun !== 1'b0) begin
        waveErr++;
      end
      if (c == 2) checkOutput("ready at T+2", idx, 32'(s_ready), 32'(sbq.size() == 0));

      ph = (c - 1) % BIT_CYC;
      k  = (c - 1) / BIT_CYC;
      j  = k % SB;
      eb = (ph >= BH);
      el = (k < SB);
      ed = (j < SW) ? ((k < SB) ? expP.l[SW-1-j] : expP.r[SW-1-j]) : 1'b0;
      if (bclk !== eb || lrck !== el || sdata !== ed) begin
        waveErr++;
        if (waveErr <= 3)
          $display("[TB]   vector %0d cycle T+%0d: bclk/lrck/sdata got %b%b%b want %b%b%b",
                   idx, c, bclk, lrck, sdata, eb, el, ed);
      end
      if (ph == 0 && j < SW) begin
        if (k < SB) rxL[SW-1-j] = sdata;
        else        rxR[SW-1-j] = sdata;
      end
      if (frame_err === 1'b1) errPulses++;

      if (c == 5 && v.midAcc) begin
        s_left  = v.ml;
        s_right = v.mr;
        s_valid = 1'b1;
        checkOutput("mid-frame ready", idx, 32'(s_ready), 32'd1);
        sbq.push_back('{l: v.ml, r: v.mr});
      end
      if (c == 6 && v.midAcc) s_valid = 1'b0;
      if (c == 10) sample_clk = 1'b0;
      if (c == 20 && v.injectErr) sample_clk = 1'b1;
      if (c == 25) sample_clk = 1'b0;

      if (c == v.abortAt) begin
        reset = 1'b1;
        #1;
        checkOutput("ready during reset", idx, 32'(s_ready), 32'd0);
        sbq.delete();
        lastL = '0;
        lastR = '0;
        @(negedge clk_in);
        checkOutput("outputs after abort", idx,
                    32'({bclk, lrck, sdata, underrun, frame_err}), 32'd0);
        reset = 1'b0;
        @(negedge clk_in);
        checkOutput("ready after abort", idx, 32'(s_ready), 32'd1);
        break;
      end
    end

    checkOutput("waveform errors", idx, 32'(waveErr), 32'd0);
    checkOutput("left sample", idx, 32'(rxL), 32'(expP.l));
    if (v.abortAt == 0) begin
      checkOutput("right sample", idx, 32'(rxR), 32'(expP.r));
      checkOutput("frame_err pulses", idx, 32'(errPulses), 32'(v.injectErr));
      @(negedge clk_in);
      checkOutput("idle after frame", idx, 32'({bclk, lrck, sdata}), 32'd0);
    end
  endtask

  initial begin
    //               give l      r      bp  same sl     sr     mid ml     mr     err abort expU
    vecs[0]  = mkVec(1, 8'hA5, 8'h3C, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0,  0);
    vecs[1]  = mkVec(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0,  1);
    vecs[2]  = mkVec(1, 8'h11, 8'hEE, 0, 0, 8'h00, 8'h00, 1, 8'h77, 8'h88, 1, 0,  0);
    vecs[3]  = mkVec(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0,  0);
    vecs[4]  = mkVec(1, 8'h5A, 8'hC3, 1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0,  0);
    vecs[5]  = mkVec(0, 8'h00, 8'h00, 0, 1, 8'h12, 8'h34, 0, 8'h00, 8'h00, 0, 0,  1);
    vecs[6]  = mkVec(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0,  0);
    vecs[7]  = mkVec(1, 8'h80, 8'h01, 0, 0, 8'h00, 8'h00, 1, 8'h42, 8'h24, 0, 40, 0);
    vecs[8]  = mkVec(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0,  1);
    vecs[9]  = mkVec(1, 8'hFF, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0,  0);
    vecs[10] = mkVec(1, 8'h01, 8'h80, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0,  0);

    $display("[TB] starting i2s_lj_transmitter bench");
    reset = 1'b1;
    repeat (3) @(negedge clk_in);
    checkOutput("reset outputs", -1, 32'({bclk, lrck, sdata, underrun, frame_err}), 32'd0);
    checkOutput("reset ready", -1, 32'(s_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk_in);
    checkOutput("ready after reset", -1, 32'(s_ready), 32'd1);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(i, vecs[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/i2s_lj_transmitter.md
# i2s_lj_transmitter

Serializes stereo PCM samples into a left-justified serial audio stream (BCLK/LRCK/SDATA) for an external DAC. Sits directly downstream of the sample-rate clock divider: its `sample_clk` input is that divider's `clk_out`, and each rising edge starts one stereo frame. The synth voice/mixer path feeds it through a one-entry valid/ready holding register.

## Interface

**Parameters**
- `SAMPLE_WIDTH`, default 16: bits per channel sample, two's complement. Must be ≤ `SLOT_BITS`.
- `SLOT_BITS`, default 32: BCLK periods per channel slot.
- `BCLK_HALF`, default 8: `clk_in` cycles per BCLK half-period, ≥ 1.
  - Frame length is `4*SLOT_BITS*BCLK_HALF` cycles (1024 at defaults).
  - This must be < the sample period in `clk_in` cycles (1133 at 50 MHz / 44.1 kHz).

**Ports**
- `clk_in`, in, 1: system clock. All logic is on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `sample_clk`, in, 1: divided sample-rate clock, same clock domain as `clk_in`.
- `s_left`, in, `SAMPLE_WIDTH`: left sample.
- `s_right`, in, `SAMPLE_WIDTH`: right sample.
- `s_valid`, in, 1: sample pair valid.
- `s_ready`, out, 1: holding register empty.
- `bclk`, out, 1: bit clock.
- `lrck`, out, 1: 1 = left slot, 0 = right slot.
- `sdata`, out, 1: serial data, MSB first.
- `underrun`, out, 1: one-cycle pulse; frame started with no new sample held.
- `frame_err`, out, 1: one-cycle pulse; sample tick arrived during an active frame.

## Operation

- **Tick detect.** Register `sample_clk` into `sc_d`. A tick occurs when `sample_clk & ~sc_d`. No synchronizer is used, because the signal is in the same clock domain.
- **Holding register.**
  - `s_ready = ~hold_full`.
  - When `s_valid & s_ready`, capture `s_left`/`s_right` and set `hold_full`.
- **States: IDLE and ACTIVE.**
- **IDLE + tick:**
  - If `hold_full`: load the shift pair from the holding register and clear `hold_full`.
  - Otherwise: pulse `underrun` and load the fallback data (see Configuration).
  - Go to ACTIVE with bit index 0.
- **ACTIVE bit timing.**
  - Bit k (0 … `2*SLOT_BITS-1`) lasts `2*BCLK_HALF` cycles: `bclk`=0 for `BCLK_HALF` cycles, then `bclk`=1 for `BCLK_HALF` cycles.
  - `lrck` and `sdata` change only at the start of a bit, i.e. on the BCLK falling edge.
- **ACTIVE slot contents.**
  - Bits 0 … `SLOT_BITS-1`: `lrck`=1, left slot.
  - Bits `SLOT_BITS` … `2*SLOT_BITS-1`: `lrck`=0, right slot.
  - Within a slot, the first `SAMPLE_WIDTH` bits carry the sample MSB-first, starting in the same bit as the `lrck` transition (left-justified). The remaining slot bits are 0.
- **End of frame.** After the high phase of the last bit, return to IDLE with `bclk`=0, `lrck`=0, `sdata`=0.
- **Tick in ACTIVE.** Ignored for framing, and `frame_err` pulses. The holding register is not consumed.
- **Tick and accept in the same cycle with the register empty.** The frame underruns. The accepted pair is held for the next frame; there is no bypass.
- **Tick with the register full and `s_valid`=1.** The held pair transfers to the shift pair. Nothing is accepted that cycle; `s_ready` rises the next cycle.

## Timing

- **Reset values:** `bclk`=0, `lrck`=0, `sdata`=0, `underrun`=0, `frame_err`=0, `s_ready`=0 while `reset` is high. State=IDLE, `hold_full`=0, `sc_d`=0, shift pair and last-sample register =0.
- **After reset:** `s_ready`=1 in the first cycle after reset deasserts.
- **Reset mid-frame:** aborts the frame immediately. All outputs return to reset values on the next edge, and any held sample is discarded.
- **Tick detected in cycle T:**
  - Cycle T+1: `lrck`=1, `sdata`=left MSB, `bclk`=0, `underrun` valid.
  - Bit k starts at T+1+2·`BCLK_HALF`·k.
  - `bclk` rises at T+1+`BCLK_HALF`·(2k+1).
  - Right slot starts at T+1+2·`BCLK_HALF`·`SLOT_BITS` (T+513 at defaults).
  - IDLE outputs appear at T+1+4·`BCLK_HALF`·`SLOT_BITS` (T+1025).
- **`frame_err`:** asserted in the cycle after the ignored tick.
- **Input latency:** a sample accepted at cycle A is transmitted at the first tick detected at or after A+1.

## Configuration

- **`I2S_UNDERRUN_REPEAT_EN` defined:** on underrun, the frame retransmits the last transmitted pair, which is stored in a last-sample register updated at every frame load.
- **`I2S_UNDERRUN_REPEAT_EN` undefined:** on underrun, the frame transmits all-zero slots, and the last-sample register is not built.
- **Both variants:** `underrun` pulses identically.

## Test plan

All scenarios use `SAMPLE_WIDTH`=8, `SLOT_BITS`=8, `BCLK_HALF`=2 (64-cycle frame), with `sample_clk` from a divider with DIVISOR=80.

- **Basic frame.** Accept L=0xA5, R=0x3C, then tick at T.
  - `lrck`=1 over T+1..T+32 and 0 over T+33..T+64.
  - `sdata` is 10100101 then 00111100, one bit per 4 cycles.
  - IDLE at T+65; `s_ready`=1 at T+2.
- **Underrun.** No sample before the tick → `underrun`=1 at T+1.
  - Repeat build: the previous pair is sent.
  - Non-repeat build: 0x00/0x00 is sent.
- **Back-pressure.** Hold `s_valid`=1 with the register full → `s_ready`=0 and no overwrite. The next tick consumes the pair and `s_ready`=1 one cycle later.
- **Same-cycle tick and accept with the register empty** → `underrun` pulses, and the accepted pair appears on the following frame.
- **Frame error.** Force a second rising edge of `sample_clk` 20 cycles into a frame → `frame_err` pulses once, and the current frame completes unchanged.
- **Reset mid-frame.** Assert `reset` at T+40 → all outputs are 0 on the next edge. After release, the next tick produces `underrun`.
